// File: rtl/wav_apb_fifo_pkg.sv
// Register map constants shared by the APB FIFO port register block.
// Each channel owns a 16-byte window holding four word registers.
package wav_apb_fifo_pkg;

  localparam int CH_STRIDE = 'h10;
  localparam int CH_SHIFT  = $clog2(CH_STRIDE);

  localparam logic [3:0] OFF_TXDATA = 4'h0;
  localparam logic [3:0] OFF_RXDATA = 4'h4;
  localparam logic [3:0] OFF_STATUS = 4'h8;
  localparam logic [3:0] OFF_FLAGS  = 4'hC;

  localparam int ST_RX_LEVEL_LSB = 8;
  localparam int ST_TX_FULL      = 16;
  localparam int ST_TX_EMPTY     = 17;
  localparam int ST_RX_FULL      = 18;
  localparam int ST_RX_EMPTY     = 19;

  localparam int FL_TX_OVF = 0;
  localparam int FL_RX_UDF = 1;

  localparam int CTL_FLUSH_TX = 0;
  localparam int CTL_FLUSH_RX = 1;

  typedef enum logic [1:0] {
    REG_TXDATA,
    REG_RXDATA,
    REG_STATUS,
    REG_FLAGS
  } reg_sel_e;

endpackage

// File: rtl/wav_sync_fifo_ff.sv
// Single-clock flop FIFO with push/pop/flush and level reporting.
// Pointers carry one extra wrap bit so full and empty are distinguishable.
module wav_sync_fifo_ff #(
  parameter  int DATA_WIDTH = 8,
  parameter  int DEPTH      = 4,
  localparam int AW         = $clog2(DEPTH)
) (
  input  logic                  RegClk,
  input  logic                  RegReset,
  input  logic                  push,
  input  logic [DATA_WIDTH-1:0] push_data,
  input  logic                  pop,
  input  logic                  flush,
  output logic [DATA_WIDTH-1:0] head,
  output logic                  full,
  output logic                  empty,
  output logic [AW:0]           level
);

  logic [DATA_WIDTH-1:0] mem_reg [DEPTH];
  logic [AW:0]           wr_ptr_reg;
  logic [AW:0]           rd_ptr_reg;
  logic                  push_ok;
  logic                  pop_ok;

  assign full    = (wr_ptr_reg[AW] != rd_ptr_reg[AW]) &&
                   (wr_ptr_reg[AW-1:0] == rd_ptr_reg[AW-1:0]);
  assign empty   = (wr_ptr_reg == rd_ptr_reg);
  assign level   = wr_ptr_reg - rd_ptr_reg;
  assign push_ok = push && !full;
  assign pop_ok  = pop && !empty;

  // Head reads as zero when empty so stale entries never leak onto the bus.
  assign head = empty ? '0 : mem_reg[rd_ptr_reg[AW-1:0]];

  always_ff @(posedge RegClk or posedge RegReset) begin
    if (RegReset) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
    end else if (flush) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
    end else begin
      if (push_ok) wr_ptr_reg <= wr_ptr_reg + 1'b1;
      if (pop_ok)  rd_ptr_reg <= rd_ptr_reg + 1'b1;
    end
  end

  always_ff @(posedge RegClk) begin
    if (push_ok) mem_reg[wr_ptr_reg[AW-1:0]] <= push_data;
  end

endmodule

// File: rtl/wav_apb_fifo_port_regs.sv
// APB slave exposing NUM_CH TX/RX FIFO pairs with status, sticky error flags and irq.
// Writes act on the registered setup-phase address/data; reads decode combinationally.
module wav_apb_fifo_port_regs
  import wav_apb_fifo_pkg::*;
#(
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH      = 4,
  parameter int NUM_CH     = 2
) (
  input  logic                         RegClk,
  input  logic                         RegReset,
  input  logic                         PSEL,
  input  logic                         PENABLE,
  input  logic                         PWRITE,
  input  logic [ADDR_WIDTH-1:0]        PADDR,
  input  logic [31:0]                  PWDATA,
  output logic [31:0]                  PRDATA,
  output logic                         PREADY,
  output logic                         PSLVERR,
  output logic [NUM_CH*DATA_WIDTH-1:0] tx_data,
  output logic [NUM_CH-1:0]            tx_valid,
  input  logic [NUM_CH-1:0]            tx_ready,
  input  logic [NUM_CH*DATA_WIDTH-1:0] rx_data,
  input  logic [NUM_CH-1:0]            rx_valid,
  output logic [NUM_CH-1:0]            rx_ready,
  output logic                         irq
);

  localparam int LW  = $clog2(DEPTH + 1);
  localparam int CHW = ADDR_WIDTH - CH_SHIFT;

  logic [ADDR_WIDTH-1:0]    addr_reg;
  logic [31:0]              wdata_reg;
  logic                     wr_sel_reg;
  logic                     wr_stb;
  logic                     rd_stb;
  logic [CHW-1:0]           ch_idx;
  logic [CH_SHIFT-1:0]      off;
  reg_sel_e                 reg_sel;
  logic                     off_ok;
  logic                     addr_ok;
  logic [NUM_CH-1:0]        err_vec;
  logic [NUM_CH-1:0]        flag_vec;
  logic [NUM_CH-1:0][31:0]  rd_word;
  logic [31:0]              prdata_mux;
  logic                     unused_wdata;

  always_ff @(posedge RegClk or posedge RegReset) begin
    if (RegReset) begin
      addr_reg   <= '0;
      wdata_reg  <= '0;
      wr_sel_reg <= 1'b0;
    end else begin
      if (PSEL) begin
        addr_reg  <= PADDR;
        wdata_reg <= PWDATA;
      end
      wr_sel_reg <= PSEL & PWRITE;
    end
  end

  assign wr_stb       = wr_sel_reg & PENABLE;
  assign rd_stb       = PSEL & PENABLE & ~PWRITE;
  assign ch_idx       = addr_reg[ADDR_WIDTH-1:CH_SHIFT];
  assign off          = addr_reg[CH_SHIFT-1:0];
  assign unused_wdata = ^wdata_reg;

  always_comb begin
    off_ok  = 1'b1;
    reg_sel = REG_TXDATA;
    case (off)
      OFF_TXDATA: reg_sel = REG_TXDATA;
      OFF_RXDATA: reg_sel = REG_RXDATA;
      OFF_STATUS: reg_sel = REG_STATUS;
      OFF_FLAGS:  reg_sel = REG_FLAGS;
      default:    off_ok  = 1'b0;
    endcase
  end

  assign addr_ok = off_ok && (ch_idx < CHW'(NUM_CH));

  genvar gi;
  generate
    for (gi = 0; gi < NUM_CH; gi++) begin : g_ch
      logic                  hit, acc_wr, acc_rd;
      logic                  tx_push, tx_flush, rx_pop, rx_flush;
      logic                  ovf_set, udf_set, flags_wr;
      logic                  tx_full, tx_empty, rx_full, rx_empty;
      logic [LW-1:0]         tx_level, rx_level;
      logic [DATA_WIDTH-1:0] tx_head, rx_head;
      logic                  tx_ovf_reg, rx_udf_reg;
      logic [31:0]           word;

      assign hit      = addr_ok && (ch_idx == CHW'(gi));
      assign acc_wr   = wr_stb & hit;
      assign acc_rd   = rd_stb & hit;
      // Full/empty checks use the pre-edge state, so a concurrent core pop never rescues a push.
      assign tx_push  = acc_wr && (reg_sel == REG_TXDATA) && !tx_full;
      assign ovf_set  = acc_wr && (reg_sel == REG_TXDATA) && tx_full;
      assign rx_pop   = acc_rd && (reg_sel == REG_RXDATA) && !rx_empty;
      assign udf_set  = acc_rd && (reg_sel == REG_RXDATA) && rx_empty;
      assign tx_flush = acc_wr && (reg_sel == REG_STATUS) && wdata_reg[CTL_FLUSH_TX];
      assign rx_flush = acc_wr && (reg_sel == REG_STATUS) && wdata_reg[CTL_FLUSH_RX];
      assign flags_wr = acc_wr && (reg_sel == REG_FLAGS);

      wav_sync_fifo_ff #(.DATA_WIDTH(DATA_WIDTH), .DEPTH(DEPTH)) u_tx_fifo (
        .RegClk   (RegClk),
        .RegReset (RegReset),
        .push     (tx_push),
        .push_data(wdata_reg[DATA_WIDTH-1:0]),
        .pop      (tx_ready[gi]),
        .flush    (tx_flush),
        .head     (tx_head),
        .full     (tx_full),
        .empty    (tx_empty),
        .level    (tx_level)
      );

      wav_sync_fifo_ff #(.DATA_WIDTH(DATA_WIDTH), .DEPTH(DEPTH)) u_rx_fifo (
        .RegClk   (RegClk),
        .RegReset (RegReset),
        .push     (rx_valid[gi]),
        .push_data(rx_data[gi*DATA_WIDTH +: DATA_WIDTH]),
        .pop      (rx_pop),
        .flush    (rx_flush),
        .head     (rx_head),
        .full     (rx_full),
        .empty    (rx_empty),
        .level    (rx_level)
      );

      // Set dominates a simultaneous write-one-to-clear.
      always_ff @(posedge RegClk or posedge RegReset) begin
        if (RegReset) begin
          tx_ovf_reg <= 1'b0;
          rx_udf_reg <= 1'b0;
        end else begin
          tx_ovf_reg <= ovf_set | (tx_ovf_reg & ~(flags_wr & wdata_reg[FL_TX_OVF]));
          rx_udf_reg <= udf_set | (rx_udf_reg & ~(flags_wr & wdata_reg[FL_RX_UDF]));
        end
      end

      always_comb begin
        word = '0;
        case (reg_sel)
          REG_RXDATA: word[DATA_WIDTH-1:0] = rx_head;
          REG_STATUS: begin
            word[LW-1:0]                 = tx_level;
            word[ST_RX_LEVEL_LSB +: LW]  = rx_level;
            word[ST_TX_FULL]             = tx_full;
            word[ST_TX_EMPTY]            = tx_empty;
            word[ST_RX_FULL]             = rx_full;
            word[ST_RX_EMPTY]            = rx_empty;
          end
          REG_FLAGS: begin
            word[FL_TX_OVF] = tx_ovf_reg;
            word[FL_RX_UDF] = rx_udf_reg;
          end
          default: word = '0;
        endcase
      end

      assign rd_word[gi]                           = word;
      assign err_vec[gi]                           = ovf_set | udf_set;
      assign flag_vec[gi]                          = tx_ovf_reg | rx_udf_reg;
      assign tx_data[gi*DATA_WIDTH +: DATA_WIDTH]  = tx_head;
      assign tx_valid[gi]                          = ~tx_empty;
      assign rx_ready[gi]                          = ~rx_full;
    end
  endgenerate

  always_comb begin
    prdata_mux = '0;
    for (int c = 0; c < NUM_CH; c++) begin
      if (ch_idx == CHW'(c)) prdata_mux = rd_word[c];
    end
  end

  assign PRDATA  = (rd_stb && addr_ok) ? prdata_mux : '0;
  assign PSLVERR = ((wr_stb | rd_stb) & ~addr_ok) | (|err_vec);
  assign PREADY  = 1'b1;
  assign irq     = |flag_vec;

endmodule

// File: tb/tb_wav_apb_fifo_port_regs.sv
// Self-checking bench: queue-based reference model checked every cycle, a vector table,
// directed multi-cycle sequences and a randomized traffic phase.
module tb_wav_apb_fifo_port_regs;

  localparam int AWD   = 8;
  localparam int DW    = 8;
  localparam int DEPTH = 4;
  localparam int NCH   = 2;

  logic              RegClk = 1'b0;
  logic              RegReset;
  logic              PSEL, PENABLE, PWRITE;
  logic [AWD-1:0]    PADDR;
  logic [31:0]       PWDATA, PRDATA;
  logic              PREADY, PSLVERR;
  logic [NCH*DW-1:0] tx_data, rx_data;
  logic [NCH-1:0]    tx_valid, tx_ready, rx_valid, rx_ready;
  logic              irq;

  always #5 RegClk = ~RegClk;

  wav_apb_fifo_port_regs #(.ADDR_WIDTH(AWD), .DATA_WIDTH(DW), .DEPTH(DEPTH), .NUM_CH(NCH)) dut (
    .RegClk(RegClk), .RegReset(RegReset), .PSEL(PSEL), .PENABLE(PENABLE), .PWRITE(PWRITE),
    .PADDR(PADDR), .PWDATA(PWDATA), .PRDATA(PRDATA), .PREADY(PREADY), .PSLVERR(PSLVERR),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready), .rx_data(rx_data),
    .rx_valid(rx_valid), .rx_ready(rx_ready), .irq(irq)
  );

  int errors = 0;
  int checks = 0;

  logic [DW-1:0] txq [NCH][$];
  logic [DW-1:0] rxq [NCH][$];
  bit            m_ovf [NCH];
  bit            m_udf [NCH];

  logic [31:0] rdv;
  logic        erv;

  typedef struct {
    bit          wr;
    logic [7:0]  addr;
    logic [31:0] wd;
    logic [31:0] exp_rd;
    bit          exp_err;
  } vec_t;
  vec_t tbl [16];

  function automatic void check(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endfunction

  function automatic logic [31:0] m_status(int c);
    logic [31:0] s;
    s = 32'(txq[c].size()) | (32'(rxq[c].size()) << 8);
    if (txq[c].size() == DEPTH) s |= 32'h0001_0000;
    if (txq[c].size() == 0)     s |= 32'h0002_0000;
    if (rxq[c].size() == DEPTH) s |= 32'h0004_0000;
    if (rxq[c].size() == 0)     s |= 32'h0008_0000;
    return s;
  endfunction

  function automatic void model_clear();
    for (int c = 0; c < NCH; c++) begin
      txq[c].delete();
      rxq[c].delete();
      m_ovf[c] = 0;
      m_udf[c] = 0;
    end
  endfunction

  // One clock cycle: drive, compare every output to the model, then advance the model.
  task automatic cyc(input bit sel, input bit en, input bit wr, input logic [7:0] addr,
                     input logic [31:0] wd, input logic [NCH-1:0] trdy, input logic [NCH-1:0] rvld,
                     input logic [NCH*DW-1:0] rdat, output logic [31:0] rdata, output logic err);
    int ch, off, txn[NCH], rxn[NCH];
    bit ok, acc, e_err, e_irq;
    logic [31:0] e_rd;
    logic [NCH*DW-1:0] e_txd;
    logic [NCH-1:0] e_txv, e_rxr;
    @(negedge RegClk);
    PSEL = sel; PENABLE = en; PWRITE = wr; PADDR = addr; PWDATA = wd;
    tx_ready = trdy; rx_valid = rvld; rx_data = rdat;
    #1;
    e_irq = 0;
    for (int c = 0; c < NCH; c++) begin
      txn[c] = txq[c].size();
      rxn[c] = rxq[c].size();
      e_txv[c] = (txn[c] > 0);
      e_txd[c*DW +: DW] = (txn[c] > 0) ? txq[c][0] : '0;
      e_rxr[c] = (rxn[c] < DEPTH);
      e_irq |= m_ovf[c] | m_udf[c];
    end
    acc = sel && en;
    ch  = int'(addr) >> 4;
    off = int'(addr) & 15;
    ok  = (ch < NCH) && (off == 0 || off == 4 || off == 8 || off == 12);
    e_rd = 0; e_err = 0;
    if (acc) begin
      if (!ok) e_err = 1;
      else if (!wr) begin
        if (off == 4) begin
          if (rxn[ch] == 0) e_err = 1; else e_rd = 32'(rxq[ch][0]);
        end else if (off == 8) e_rd = m_status(ch);
        else if (off == 12) e_rd = {30'b0, m_udf[ch], m_ovf[ch]};
      end else if (off == 0 && txn[ch] == DEPTH) e_err = 1;
    end
    check("tx_valid", 32'(tx_valid), 32'(e_txv));
    check("tx_data", 32'(tx_data), 32'(e_txd));
    check("rx_ready", 32'(rx_ready), 32'(e_rxr));
    check("irq", 32'(irq), 32'(e_irq));
    check("prdata", PRDATA, e_rd);
    check("pslverr", 32'(PSLVERR), 32'(e_err));
    rdata = PRDATA;
    err   = PSLVERR;
    for (int c = 0; c < NCH; c++) begin
      if (trdy[c] && txn[c] > 0) void'(txq[c].pop_front());
      if (rvld[c] && rxn[c] < DEPTH) rxq[c].push_back(rdat[c*DW +: DW]);
    end
    if (acc && ok) begin
      if (wr) begin
        if (off == 0) begin
          if (txn[ch] < DEPTH) txq[ch].push_back(wd[DW-1:0]); else m_ovf[ch] = 1;
        end else if (off == 8) begin
          if (wd[0]) txq[ch].delete();
          if (wd[1]) rxq[ch].delete();
        end else if (off == 12) begin
          if (wd[0]) m_ovf[ch] = 0;
          if (wd[1]) m_udf[ch] = 0;
        end
      end else if (off == 4) begin
        if (rxn[ch] > 0) void'(rxq[ch].pop_front()); else m_udf[ch] = 1;
      end
    end
  endtask

  task automatic apb(input bit wr, input logic [7:0] addr, input logic [31:0] wd,
                     input logic [NCH-1:0] trdy, input logic [NCH-1:0] rvld,
                     input logic [NCH*DW-1:0] rdat, output logic [31:0] rdata, output logic err);
    logic [31:0] d;
    logic e;
    cyc(1, 0, wr, addr, wd, '0, '0, '0, d, e);
    cyc(1, 1, wr, addr, wd, trdy, rvld, rdat, rdata, err);
  endtask

  task automatic wr_reg(input logic [7:0] a, input logic [31:0] d);
    logic [31:0] r;
    logic e;
    apb(1, a, d, '0, '0, '0, r, e);
  endtask

  task automatic rd_reg(input logic [7:0] a, output logic [31:0] d, output logic e);
    apb(0, a, 32'h0, '0, '0, '0, d, e);
  endtask

  task automatic core(input logic [NCH-1:0] trdy, input logic [NCH-1:0] rvld,
                      input logic [NCH*DW-1:0] rdat);
    logic [31:0] r;
    logic e;
    cyc(0, 0, 0, 8'h0, 32'h0, trdy, rvld, rdat, r, e);
  endtask

  task automatic do_reset();
    @(negedge RegClk);
    PSEL = 0; PENABLE = 0; tx_ready = '1; rx_valid = '1; rx_data = '1;
    #2 RegReset = 1;
    #1;
    check("rst_tx_valid", 32'(tx_valid), 32'h0);
    check("rst_rx_ready", 32'(rx_ready), 32'h3);
    check("rst_tx_data", 32'(tx_data), 32'h0);
    check("rst_irq", 32'(irq), 32'h0);
    check("rst_prdata", PRDATA, 32'h0);
    check("rst_pslverr", 32'(PSLVERR), 32'h0);
    @(negedge RegClk);
    tx_ready = '0; rx_valid = '0;
    #1 RegReset = 0;
    model_clear();
  endtask

  initial begin
    logic [7:0] drain [4];
    int c_r, o_r, sel_r;
    logic [7:0] a_r;
    logic [31:0] wd_r;

    tbl[0]  = '{1, 8'h00, 32'h11, 32'h0, 0};
    tbl[1]  = '{1, 8'h00, 32'h22, 32'h0, 0};
    tbl[2]  = '{1, 8'h00, 32'h33, 32'h0, 0};
    tbl[3]  = '{1, 8'h00, 32'h44, 32'h0, 0};
    tbl[4]  = '{0, 8'h08, 32'h0, 32'h0009_0004, 0};
    tbl[5]  = '{1, 8'h00, 32'h55, 32'h0, 1};
    tbl[6]  = '{0, 8'h0C, 32'h0, 32'h1, 0};
    tbl[7]  = '{0, 8'h40, 32'h0, 32'h0, 1};
    tbl[8]  = '{1, 8'h40, 32'hFF, 32'h0, 1};
    tbl[9]  = '{0, 8'h03, 32'h0, 32'h0, 1};
    tbl[10] = '{0, 8'h04, 32'h0, 32'h0, 1};
    tbl[11] = '{0, 8'h0C, 32'h0, 32'h3, 0};
    tbl[12] = '{1, 8'h0C, 32'h2, 32'h0, 0};
    tbl[13] = '{0, 8'h0C, 32'h0, 32'h1, 0};
    tbl[14] = '{0, 8'h00, 32'h0, 32'h0, 0};
    tbl[15] = '{1, 8'h04, 32'h99, 32'h0, 0};
    drain = '{8'h11, 8'h22, 8'h33, 8'h44};

    RegReset = 1; PSEL = 0; PENABLE = 0; PWRITE = 0; PADDR = '0; PWDATA = '0;
    tx_ready = '0; rx_valid = '0; rx_data = '0;
    model_clear();
    #1;
    check("init_tx_valid", 32'(tx_valid), 32'h0);
    check("init_rx_ready", 32'(rx_ready), 32'h3);
    check("init_irq", 32'(irq), 32'h0);
    #11 RegReset = 0;

    // TX fill, overflow, address errors and flag handling.
    for (int i = 0; i < 16; i++) begin
      apb(tbl[i].wr, tbl[i].addr, tbl[i].wd, '0, '0, '0, rdv, erv);
      check($sformatf("tbl%0d_rdata", i), rdv, tbl[i].exp_rd);
      check($sformatf("tbl%0d_err", i), 32'(erv), 32'(tbl[i].exp_err));
    end
    check("ovf_irq", 32'(irq), 32'h1);

    // Drain ch0 TX: order preserved, overflowed 0x55 never appears.
    for (int i = 0; i < 4; i++) begin
      core(2'b01, '0, '0);
      check($sformatf("drain%0d", i), 32'(tx_data[7:0]), 32'(drain[i]));
    end
    core(2'b00, '0, '0);
    check("drain_empty", 32'(tx_valid[0]), 32'h0);
    wr_reg(8'h0C, 32'h3);
    rd_reg(8'h0C, rdv, erv);
    check("flags_cleared", rdv, 32'h0);

    // RX on ch1 then underflow.
    core('0, 2'b10, 16'hA500);
    core('0, 2'b10, 16'h5A00);
    rd_reg(8'h14, rdv, erv); check("rx_first", rdv, 32'hA5);
    rd_reg(8'h14, rdv, erv); check("rx_second", rdv, 32'h5A);
    rd_reg(8'h14, rdv, erv); check("rx_udf_data", rdv, 32'h0);
    check("rx_udf_err", 32'(erv), 32'h1);
    rd_reg(8'h1C, rdv, erv); check("rx_udf_flag", rdv, 32'h2);
    wr_reg(8'h1C, 32'h2);

    // Simultaneous APB push and core pop keeps level; flush beats a concurrent pop.
    wr_reg(8'h00, 32'h61);
    wr_reg(8'h00, 32'h62);
    apb(1, 8'h00, 32'h63, 2'b01, '0, '0, rdv, erv);
    rd_reg(8'h08, rdv, erv); check("simul_level", rdv, 32'h0008_0002);
    apb(1, 8'h08, 32'h1, 2'b01, '0, '0, rdv, erv);
    rd_reg(8'h08, rdv, erv); check("flush_status", rdv, 32'h000A_0000);
    rd_reg(8'h0C, rdv, erv); check("flush_noflag", rdv, 32'h0);

    // Push to a full FIFO is rejected even while the core pops.
    for (int i = 0; i < DEPTH; i++) wr_reg(8'h00, 32'h71 + i);
    apb(1, 8'h00, 32'h75, 2'b01, '0, '0, rdv, erv);
    check("full_pop_push_err", 32'(erv), 32'h1);
    rd_reg(8'h08, rdv, erv); check("full_pop_level", rdv, 32'h0008_0003);
    wr_reg(8'h0C, 32'h3);
    wr_reg(8'h08, 32'h3);

    // Pointer wrap on ch1 TX and RX.
    for (int r = 0; r < 3; r++) begin
      for (int k = 0; k < DEPTH; k++) wr_reg(8'h10, 32'(r * 16 + k));
      rd_reg(8'h18, rdv, erv); check($sformatf("wrap%0d_full", r), rdv, 32'h0009_0004);
      for (int k = 0; k < DEPTH; k++) begin
        core(2'b10, 2'b10, 16'(((r * 16 + k) ^ 8'hC3) << 8));
        check($sformatf("wrap%0d_%0d", r, k), 32'(tx_data[15:8]), 32'(r * 16 + k));
      end
      for (int k = 0; k < DEPTH; k++) rd_reg(8'h14, rdv, erv);
    end

    // Reset in the middle of traffic.
    wr_reg(8'h00, 32'hAA);
    wr_reg(8'h00, 32'hBB);
    core('0, 2'b11, 16'h1234);
    do_reset();
    rd_reg(8'h08, rdv, erv); check("post_rst_status", rdv, 32'h000A_0000);

    // Randomized traffic against the model.
    for (int i = 0; i < 400; i++) begin
      sel_r = $urandom_range(0, 3);
      if (sel_r == 0) begin
        core(NCH'($urandom), NCH'($urandom), (NCH*DW)'($urandom));
      end else begin
        c_r = $urandom_range(0, NCH);
        o_r = $urandom_range(0, 4);
        a_r = 8'(c_r * 16 + ((o_r == 4) ? $urandom_range(0, 15) : o_r * 4));
        wd_r = $urandom;
        if (a_r[3:0] == 4'h8 && $urandom_range(0, 3) != 0) wd_r[1:0] = 2'b00;
        apb(1'($urandom), a_r, wd_r, NCH'($urandom), NCH'($urandom),
            (NCH*DW)'($urandom), rdv, erv);
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
